display_driver: RTL and testbench

DISPLAY_DRIVER -- requirements
Module: display_driver

---
 rtl/display_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/display_driver.sv | 86 ++++++++
 tb/tb_display_driver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, sizes and the double-dabble step for the display driver.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_VALUE  = 9999;
    localparam int BIN_WIDTH  = 14;
    localparam int BCD_WIDTH  = 4 * NUM_DIGITS;
    localparam int SR_WIDTH   = BCD_WIDTH + BIN_WIDTH;

    // One double-dabble iteration on the combined {bcd, bin} register:
    // add 3 to every BCD nibble that is 5 or more, then shift left by one.
    function automatic logic [SR_WIDTH-1:0] dd_step(input logic [SR_WIDTH-1:0] sr_in);
        logic [SR_WIDTH-1:0] t;
        t = sr_in;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (t[BIN_WIDTH + 4*n +: 4] >= 4'd5)
                t[BIN_WIDTH + 4*n +: 4] = t[BIN_WIDTH + 4*n +: 4] + 4'd3;
        end
        return {t[SR_WIDTH-2:0], 1'b0};
    endfunction

    // Clamp an out-of-range binary value to the largest displayable number.
    function automatic logic [BIN_WIDTH-1:0] saturate(input logic [BIN_WIDTH-1:0] v);
        return (v > BIN_WIDTH'(MAX_VALUE)) ? BIN_WIDTH'(MAX_VALUE) : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; sr holds the last finished conversion
//   SHIFT  | one add-3/shift iteration per cycle, 14 iterations in total
//   COMMIT | result stable in sr; done pulses so the owner can latch bcd
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd
);

    state_t              state, state_nxt;
    logic [3:0]          iter, iter_nxt;
    logic [SR_WIDTH-1:0] sr, sr_nxt;
    logic                busy_nxt;

    // State, iteration counter, shift register and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
            sr    <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            iter  <= iter_nxt;
            sr    <= sr_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state logic; busy is precomputed from the next state so the
    // flop output equals (state != IDLE) without a combinational path.
    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
        sr_nxt    = sr;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_nxt    = {{BCD_WIDTH{1'b0}}, bin};
                    iter_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sr_nxt   = dd_step(sr);
                iter_nxt = iter + 4'd1;
                if (iter == 4'(BIN_WIDTH - 1))
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    assign bcd = sr[SR_WIDTH-1 -: BCD_WIDTH];

endmodule

// File: rtl/display_driver.sv
// Four-digit multiplexed BCD display driver with saturating binary input,
// sequential conversion and optional leading-zero blanking.
module display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIN_WIDTH-1:0] value,
    input  logic                 load,
    output logic                 busy,
    output logic                 overflow,
    output logic [3:0]           digit,
    output logic [3:0]           anode
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic                 accept;
    logic                 conv_done;
    logic [BCD_WIDTH-1:0] conv_bcd;
    logic [BCD_WIDTH-1:0] disp;
    logic [PW-1:0]        pre;
    logic                 wrap;
    logic [1:0]           pos;
    logic                 blank;

    // Loads arriving while a conversion is running are simply dropped.
    assign accept = load && !busy;
    assign wrap   = (pre == PW'(REFRESH_DIV - 1));

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .bin   (saturate(value)),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Overflow flag tracks the last accepted value; the display register
    // only changes on COMMIT so partial conversions are never visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            disp     <= '0;
        end else begin
            if (accept)
                overflow <= (value > BIN_WIDTH'(MAX_VALUE));
            if (conv_done)
                disp <= conv_bcd;
        end
    end

    // Free-running scan prescaler and digit position, untouched by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            pos <= '0;
        end else if (wrap) begin
            pre <= '0;
            pos <= pos + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Digit select and anode decode; upper positions blank when they and
    // every more-significant nibble are zero. Position 0 always lights.
    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ != 0 && pos != 2'd0) begin
            blank = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i >= int'(pos) && disp[4*i +: 4] != 4'd0)
                    blank = 1'b0;
            end
        end
        digit = disp[4*pos +: 4];
        anode = blank ? 4'b1111 : ~(4'b0001 << pos);
    end

endmodule

// File: tb/tb_display_driver.sv
// Directed bench for display_driver with a fast scan rate (REFRESH_DIV=4).
module tb_display_driver;
    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit;
    logic [3:0]  anode;

    int checks = 0;
    int errors = 0;
    int edges;
    int n;

    display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .digit    (digit),
        .anode    (anode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising edges since reset release: position = (edges/4) mod 4.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected scan output for the current position given a display value.
    task automatic check_scan1(input string tag, input logic [15:0] d);
        int p;
        logic [15:0] d_sh;
        logic [3:0] exp_an;
        p = (edges / 4) % 4;
        d_sh = d >> (4 * p);
        exp_an = 4'b1111;
        if (p == 0 || d_sh != 16'h0000)
            exp_an[p] = 1'b0;
        chk({tag, "_digit"}, {28'd0, digit}, {28'd0, d_sh[3:0]});
        chk({tag, "_anode"}, {28'd0, anode}, {28'd0, exp_an});
    endtask

    task automatic check_scan(input string tag, input logic [15:0] d, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check_scan1(tag, d);
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Counts busy cycles (bounded) while checking the old display stays put.
    task automatic count_busy(input logic [15:0] old_d, input bit ignore, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            check_scan1("hold", old_d);
            cnt++;
            if (ignore) begin
                load  = (cnt == 3 || cnt == 6);
                value = (cnt == 6) ? 14'd12000 : 14'd5678;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_digit", {28'd0, digit}, 32'd0);
        chk("rst_anode", {28'd0, anode}, 32'he);

        // 1234: busy 15 cycles, then scan 4,3,2,1
        rst = 1'b0;
        do_load(14'd1234);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        count_busy(16'h0000, 1'b0, n);
        chk("busy_len_1234", n, 15);
        check_scan("s1234", 16'h1234, 16);

        // 12000 saturates to 9999 and raises overflow
        do_load(14'd12000);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        count_busy(16'h1234, 1'b0, n);
        chk("busy_len_sat", n, 15);
        check_scan("s9999", 16'h9999, 8);

        // 5 clears overflow, upper positions blank
        do_load(14'd5);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        count_busy(16'h9999, 1'b0, n);
        check_scan("s0005", 16'h0005, 16);

        // 7 with leading-zero blanking
        do_load(14'd7);
        count_busy(16'h0005, 1'b0, n);
        chk("busy_len_7", n, 15);
        check_scan("s0007", 16'h0007, 16);

        // 1234 with loads of 5678 and 12000 during busy: both ignored
        do_load(14'd1234);
        count_busy(16'h0007, 1'b1, n);
        chk("busy_len_ignored", n, 15);
        chk("ovf_unaffected", {31'd0, overflow}, 32'd0);
        check_scan("s1234b", 16'h1234, 8);

        // 4321 aborted by async reset after 7 SHIFT iterations
        do_load(14'd4321);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ovf", {31'd0, overflow}, 32'd0);
        chk("abort_digit", {28'd0, digit}, 32'd0);
        chk("abort_anode", {28'd0, anode}, 32'he);
        @(negedge clk);

        // Release and load 9999 on the first edge: COMMIT lands on edge 16,
        // which is also a prescaler wrap from position 3 to position 0.
        rst = 1'b0;
        do_load(14'd9999);
        chk("first_edge_accept", {31'd0, busy}, 32'd1);
        count_busy(16'h0000, 1'b0, n);
        chk("busy_len_9999", n, 15);
        chk("wrap_digit", {28'd0, digit}, 32'd9);
        chk("wrap_anode", {28'd0, anode}, 32'he);
        check_scan("s9999b", 16'h9999, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
